pipe_ctrl_hazard: RTL and testbench

- Parametrised successor to the single-stage MIPS main control decoder.
- Decodes the IF/ID opcode into WB/MEM/EX control bundles and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Adds load-use hazard detection with bubble insertion, branch flush, illegal-opcode flagging and a saturating stall counter.
- Sits between the IF/ID register and the datapath stage registers of the 5-stage core.

---
 rtl/pipe_ctrl_hazard.sv | 105 ++++++++++
 tb/tb_pipe_ctrl_hazard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_hazard.sv
// Main control decode with ID/EX, EX/MEM, MEM/WB control registers; one-edge latency per stage.
// Load-use hazard drives a combinational one-cycle stall (bubble into ID/EX); branch flush beats stall.
module pipe_ctrl_hazard #(
  parameter int REGW      = 5,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_id_valid,
  input  logic [5:0]       opcode,
  input  logic [REGW-1:0]  rs,
  input  logic [REGW-1:0]  rt,
  input  logic             flush,
  output logic             stall,
  output logic             illegal,
  output logic [1:0]       id_ex_wb,
  output logic [2:0]       id_ex_mem,
  output logic [3:0]       id_ex_ex,
  output logic [1:0]       ex_mem_wb,
  output logic [2:0]       ex_mem_mem,
  output logic [1:0]       mem_wb_wb,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] mem;
    logic [3:0] ex;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  ctrl_t           dec;
  logic            dec_illegal;
  logic            uses_rt;
  logic            hz;
  ctrl_t           id_ex;
  logic [REGW-1:0] ex_rt;

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    uses_rt     = 1'b0;
    if (if_id_valid) begin
      unique case (opcode)
        OP_RTYPE: begin dec = '{wb: 2'b10, mem: 3'b000, ex: 4'b1100}; uses_rt = 1'b1; end
        OP_LW:          dec = '{wb: 2'b11, mem: 3'b100, ex: 4'b0001};
        OP_SW:    begin dec = '{wb: 2'b00, mem: 3'b010, ex: 4'b0001}; uses_rt = 1'b1; end
        OP_BEQ:   begin dec = '{wb: 2'b00, mem: 3'b001, ex: 4'b0010}; uses_rt = 1'b1; end
        OP_ADDI:        dec = '{wb: 2'b10, mem: 3'b000, ex: 4'b0001};
        default:        dec_illegal = 1'b1;
      endcase
    end
  end

  // Load in EX whose destination is read by the instruction in ID; r0 never conflicts.
  assign hz = (HAZARD_EN != 0) && if_id_valid && id_ex.mem[2] && (ex_rt != '0) &&
              ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  assign stall = hz && !flush && !rst;

  assign id_ex_wb  = id_ex.wb;
  assign id_ex_mem = id_ex.mem;
  assign id_ex_ex  = id_ex.ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex       <= '0;
      ex_rt       <= '0;
      ex_mem_wb   <= '0;
      ex_mem_mem  <= '0;
      mem_wb_wb   <= '0;
      illegal     <= 1'b0;
      stall_count <= '0;
    end else if (flush) begin
      id_ex      <= '0;
      ex_rt      <= '0;
      ex_mem_wb  <= '0;
      ex_mem_mem <= '0;
      mem_wb_wb  <= ex_mem_wb;
      illegal    <= 1'b0;
    end else if (stall) begin
      id_ex      <= '0;
      ex_rt      <= '0;
      ex_mem_wb  <= id_ex.wb;
      ex_mem_mem <= id_ex.mem;
      mem_wb_wb  <= ex_mem_wb;
      illegal    <= 1'b0;
      if (stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      id_ex      <= dec;
      ex_rt      <= rt;
      ex_mem_wb  <= id_ex.wb;
      ex_mem_mem <= id_ex.mem;
      mem_wb_wb  <= ex_mem_wb;
      illegal    <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Bench for pipe_ctrl_hazard: directed vector table, load-use saturation run, random run vs. a pipeline model.
module tb_pipe_ctrl_hazard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       if_id_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic [4:0] rs = '0;
  logic [4:0] rt = '0;
  logic       flush = 1'b0;

  always #5 clk = ~clk;

  // default instance
  logic        stall, illegal;
  logic [1:0]  id_ex_wb, ex_mem_wb, mem_wb_wb;
  logic [2:0]  id_ex_mem, ex_mem_mem;
  logic [3:0]  id_ex_ex;
  logic [15:0] stall_count;

  pipe_ctrl_hazard dut (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .opcode(opcode), .rs(rs), .rt(rt),
    .flush(flush), .stall(stall), .illegal(illegal), .id_ex_wb(id_ex_wb), .id_ex_mem(id_ex_mem),
    .id_ex_ex(id_ex_ex), .ex_mem_wb(ex_mem_wb), .ex_mem_mem(ex_mem_mem), .mem_wb_wb(mem_wb_wb),
    .stall_count(stall_count)
  );

  // 2-bit counter instance, same stimulus
  logic        s_stall, s_illegal;
  logic [1:0]  s_id_ex_wb, s_ex_mem_wb, s_mem_wb_wb;
  logic [2:0]  s_id_ex_mem, s_ex_mem_mem;
  logic [3:0]  s_id_ex_ex;
  logic [1:0]  s_stall_count;

  pipe_ctrl_hazard #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .opcode(opcode), .rs(rs), .rt(rt),
    .flush(flush), .stall(s_stall), .illegal(s_illegal), .id_ex_wb(s_id_ex_wb),
    .id_ex_mem(s_id_ex_mem), .id_ex_ex(s_id_ex_ex), .ex_mem_wb(s_ex_mem_wb),
    .ex_mem_mem(s_ex_mem_mem), .mem_wb_wb(s_mem_wb_wb), .stall_count(s_stall_count)
  );

  // hazard detection disabled
  logic        n_stall, n_illegal;
  logic [1:0]  n_id_ex_wb, n_ex_mem_wb, n_mem_wb_wb;
  logic [2:0]  n_id_ex_mem, n_ex_mem_mem;
  logic [3:0]  n_id_ex_ex;
  logic [15:0] n_stall_count;

  pipe_ctrl_hazard #(.HAZARD_EN(0)) dut_nohz (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .opcode(opcode), .rs(rs), .rt(rt),
    .flush(flush), .stall(n_stall), .illegal(n_illegal), .id_ex_wb(n_id_ex_wb),
    .id_ex_mem(n_id_ex_mem), .id_ex_ex(n_id_ex_ex), .ex_mem_wb(n_ex_mem_wb),
    .ex_mem_mem(n_ex_mem_mem), .mem_wb_wb(n_mem_wb_wb), .stall_count(n_stall_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // An instruction slot: its control word {wb,mem,ex} and its destination/rt register.
  typedef struct {
    logic [8:0] ctl;
    int         rt;
  } slot_t;

  slot_t m_idex, m_exmem, m_memwb;
  logic  m_ill;
  int    m_cnt;

  function automatic logic [8:0] ref_ctl(input logic [5:0] op, output logic known, output logic reads_rt);
    known = 1'b1; reads_rt = 1'b0;
    case (op)
      6'b000000: begin reads_rt = 1'b1; return 9'b10_000_1100; end
      6'b100011: return 9'b11_100_0001;
      6'b101011: begin reads_rt = 1'b1; return 9'b00_010_0001; end
      6'b000100: begin reads_rt = 1'b1; return 9'b00_001_0010; end
      6'b001000: return 9'b10_000_0001;
      default:   begin known = 1'b0; return 9'b0; end
    endcase
  endfunction

  function automatic logic model_stall(input logic en);
    logic known, rd;
    logic [8:0] c;
    logic is_load;
    c = ref_ctl(opcode, known, rd);
    is_load = (m_idex.ctl[6] == 1'b1);  // MemRead bit of the instruction in EX
    if (!en || rst || flush || !if_id_valid || !is_load || m_idex.rt == 0) return 1'b0;
    return (m_idex.rt == int'(rs)) || (rd && m_idex.rt == int'(rt));
  endfunction

  localparam slot_t EMPTY = '{ctl: 9'b0, rt: 0};

  logic obs_stall;

  task automatic step(input logic v, input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                      input logic f, input logic r);
    logic exp_stall, known, rd;
    logic [8:0] c;
    if_id_valid = v; opcode = op; rs = s; rt = t; flush = f; rst = r;
    #2;
    exp_stall = model_stall(1'b1);
    obs_stall = stall;
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    chk("stall_sat", {31'b0, s_stall}, {31'b0, exp_stall});
    chk("stall_nohz", {31'b0, n_stall}, 32'd0);
    c = ref_ctl(op, known, rd);
    @(posedge clk);
    if (r) begin
      m_idex = EMPTY; m_exmem = EMPTY; m_memwb = EMPTY; m_ill = 1'b0; m_cnt = 0;
    end else if (f) begin
      m_memwb = m_exmem; m_exmem = EMPTY; m_idex = EMPTY; m_ill = 1'b0;
    end else if (exp_stall) begin
      m_memwb = m_exmem; m_exmem = m_idex; m_idex = EMPTY; m_ill = 1'b0;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_memwb = m_exmem; m_exmem = m_idex;
      m_idex = v ? '{ctl: c, rt: int'(t)} : '{ctl: 9'b0, rt: int'(t)};
      m_ill = v && !known;
    end
    #1;
    chk("id_ex", {23'b0, id_ex_wb, id_ex_mem, id_ex_ex}, {23'b0, m_idex.ctl});
    chk("ex_mem", {27'b0, ex_mem_wb, ex_mem_mem}, {27'b0, m_exmem.ctl[8:4]});
    chk("mem_wb", {30'b0, mem_wb_wb}, {30'b0, m_memwb.ctl[8:7]});
    chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
    chk("stall_count", {16'b0, stall_count}, m_cnt);
    chk("stall_count_sat", {30'b0, s_stall_count}, (m_cnt > 3) ? 32'd3 : m_cnt);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       v;
    logic [5:0] op;
    logic [4:0] s, t;
    logic       f;
    logic       x_stall;    // before the edge
    logic [8:0] x_idex;     // after the edge
    logic       x_ill;
    int         x_cnt;
  } vec_t;

  vec_t tv[13];
  logic [5:0] ops[6];

  initial begin
    m_idex = EMPTY; m_exmem = EMPTY; m_memwb = EMPTY; m_ill = 1'b0; m_cnt = 0;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b111111;

    tv[0]  = '{1, 6'b000000, 5'd1, 5'd2, 0, 0, 9'b10_000_1100, 0, 0};
    tv[1]  = '{1, 6'b100011, 5'd3, 5'd5, 0, 0, 9'b11_100_0001, 0, 0};
    tv[2]  = '{1, 6'b000000, 5'd5, 5'd1, 0, 1, 9'b0,           0, 1};
    tv[3]  = '{1, 6'b000000, 5'd5, 5'd1, 0, 0, 9'b10_000_1100, 0, 1};
    tv[4]  = '{1, 6'b100011, 5'd0, 5'd5, 0, 0, 9'b11_100_0001, 0, 1};
    tv[5]  = '{1, 6'b001000, 5'd2, 5'd5, 0, 0, 9'b10_000_0001, 0, 1};
    tv[6]  = '{1, 6'b100011, 5'd1, 5'd0, 0, 0, 9'b11_100_0001, 0, 1};
    tv[7]  = '{1, 6'b000000, 5'd0, 5'd0, 0, 0, 9'b10_000_1100, 0, 1};
    tv[8]  = '{1, 6'b100011, 5'd1, 5'd7, 0, 0, 9'b11_100_0001, 0, 1};
    tv[9]  = '{1, 6'b101011, 5'd2, 5'd7, 1, 0, 9'b0,           0, 1};
    tv[10] = '{1, 6'b111111, 5'd0, 5'd0, 0, 0, 9'b0,           1, 1};
    tv[11] = '{0, 6'b111111, 5'd0, 5'd0, 0, 0, 9'b0,           0, 1};
    tv[12] = '{1, 6'b000100, 5'd1, 5'd2, 0, 0, 9'b00_001_0010, 0, 1};

    step(0, 6'd0, 5'd0, 5'd0, 0, 1);
    step(1, 6'd0, 5'd3, 5'd3, 1, 1);
    chk("reset_idex", {23'b0, id_ex_wb, id_ex_mem, id_ex_ex}, 32'd0);
    chk("reset_cnt", {16'b0, stall_count}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      step(tv[i].v, tv[i].op, tv[i].s, tv[i].t, tv[i].f, 0);
      chk($sformatf("tbl%0d_stall", i), {31'b0, obs_stall}, {31'b0, tv[i].x_stall});
      chk($sformatf("tbl%0d_idex", i), {23'b0, id_ex_wb, id_ex_mem, id_ex_ex}, {23'b0, tv[i].x_idex});
      chk($sformatf("tbl%0d_ill", i), {31'b0, illegal}, {31'b0, tv[i].x_ill});
      chk($sformatf("tbl%0d_cnt", i), {16'b0, stall_count}, tv[i].x_cnt);
      if (i == 2) chk("tbl_mem_wb_after3", {30'b0, mem_wb_wb}, 32'b10);
      if (i == 9) chk("tbl_flush_mem_wb", {30'b0, mem_wb_wb}, 32'b10);
      if (i == 9) chk("tbl_flush_ex_mem", {27'b0, ex_mem_wb, ex_mem_mem}, 32'd0);
    end
    step(1, 6'd0, 5'd0, 5'd0, 0, 0);
    chk("ill_one_cycle", {31'b0, illegal}, 32'd0);

    // five load-use pairs: wide counter reads 5, 2-bit counter saturates at 3
    step(0, 6'd0, 5'd0, 5'd0, 0, 1);
    for (int p = 0; p < 5; p++) begin
      step(1, 6'b100011, 5'd0, 5'd3, 0, 0);
      step(1, 6'b000000, 5'd3, 5'd0, 0, 0);
      step(1, 6'b000000, 5'd3, 5'd0, 0, 0);
    end
    chk("pairs_cnt", {16'b0, stall_count}, 32'd5);
    chk("pairs_sat", {30'b0, s_stall_count}, 32'd3);
    step(1, 6'b001000, 5'd1, 5'd1, 0, 0);
    step(1, 6'b001000, 5'd1, 5'd1, 0, 0);
    chk("sat_hold", {30'b0, s_stall_count}, 32'd3);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 0) op = (op == 6'b100011) ? op : ops[$urandom_range(0, 1)];
      step($urandom_range(0, 9) != 0, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 11) == 0, $urandom_range(0, 249) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
